// File: rtl/bus_pkg.sv
// Shared types for the serial bus arbiter: arbiter and receiver state encodings
// and the frame start-bit value.
package bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_TURN
  } arb_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_ID,
    RX_HOLD
  } rx_state_t;

  localparam logic FRAME_START = 1'b1;

endpackage

// File: rtl/arb_req_rx.sv
// Per-master request frame receiver: start bit, SLAVE_ID_W ID bits MSB first, then hold.
// A request is live while in hold with a legal ID and the line still high.
module arb_req_rx
  import bus_pkg::*;
#(
  parameter int SLAVES     = 4,
  parameter int SLAVE_ID_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_send,
  output logic                  o_req_live,
  output logic                  o_rx_idle,
  output logic                  o_bad_id,
  output logic [SLAVE_ID_W-1:0] o_req_id
);

  localparam int CNT_W = (SLAVE_ID_W > 1) ? $clog2(SLAVE_ID_W) : 1;
  localparam logic [SLAVE_ID_W:0] SLV_LIM = (SLAVE_ID_W+1)'(SLAVES);

  rx_state_t             r_state;
  rx_state_t             w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [SLAVE_ID_W-1:0] r_id;
  logic                  r_bad_flag;
  logic                  r_bad_pulse;
  logic [SLAVE_ID_W-1:0] w_id_shift;
  logic                  w_last;
  logic                  w_id_bad;
  logic                  w_req_valid;

  assign w_id_shift = (r_id << 1) | SLAVE_ID_W'(i_send);
  assign w_last     = (r_cnt == CNT_W'(SLAVE_ID_W - 1));
  assign w_id_bad   = ({1'b0, w_id_shift} >= SLV_LIM);

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE: if (i_send == FRAME_START) w_next = RX_ID;
      RX_ID:   if (w_last) w_next = RX_HOLD;
      RX_HOLD: if (!i_send) w_next = RX_IDLE;
      default: w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_id        <= '0;
      r_bad_flag  <= 1'b0;
      r_bad_pulse <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_bad_pulse <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt      <= '0;
          r_id       <= '0;
          r_bad_flag <= 1'b0;
        end
        RX_ID: begin
          // Line level here is ID data even if it is low; no abort mid-frame.
          r_id  <= w_id_shift;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bad_flag  <= w_id_bad;
            r_bad_pulse <= w_id_bad;
          end
        end
        RX_HOLD: if (!i_send) r_bad_flag <= 1'b0;
        default: ;
      endcase
    end
  end

  assign w_req_valid = (r_state == RX_HOLD) && !r_bad_flag;
  assign o_req_live  = w_req_valid && i_send;
  assign o_rx_idle   = (r_state == RX_IDLE);
  assign o_bad_id    = r_bad_pulse;
  assign o_req_id    = r_id;

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter sharing one serial bus among MASTERS framed requesters, with a
// grant watchdog, a stale mask for timed-out masters and a dead cycle between grants.
module serial_bus_arbiter
  import bus_pkg::*;
#(
  parameter int MASTERS    = 2,
  parameter int SLAVES     = 4,
  parameter int SLAVE_ID_W = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MASTERS-1:0]         arbSend,
  output logic [MASTERS-1:0]         arbCont,
  output logic [SLAVES-1:0]          slave_sel,
  output logic [$clog2(MASTERS)-1:0] master_sel,
  output logic                       bus_busy,
  output logic                       timeout,
  output logic                       bad_id
);

  localparam int MS_W = $clog2(MASTERS);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [MASTERS-1:0]    w_req_live;
  logic [MASTERS-1:0]    w_rx_idle;
  logic [MASTERS-1:0]    w_bad;
  logic [SLAVE_ID_W-1:0] w_req_id [MASTERS];

  for (genvar gi = 0; gi < MASTERS; gi++) begin : g_rx
    arb_req_rx #(
      .SLAVES     (SLAVES),
      .SLAVE_ID_W (SLAVE_ID_W)
    ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .i_send     (arbSend[gi]),
      .o_req_live (w_req_live[gi]),
      .o_rx_idle  (w_rx_idle[gi]),
      .o_bad_id   (w_bad[gi]),
      .o_req_id   (w_req_id[gi])
    );
  end

  arb_state_t            r_state;
  arb_state_t            w_next;
  logic [MS_W-1:0]       r_g;
  logic [MS_W-1:0]       r_ptr;
  logic [SLAVE_ID_W-1:0] r_sid;
  logic [WD_W-1:0]       r_wd;
  logic [MASTERS-1:0]    r_stale;
  logic                  r_to;
  logic [MASTERS-1:0]    w_elig;
  logic                  w_found;
  logic [MS_W-1:0]       w_pick;
  logic                  w_g_live;
  logic                  w_wd_hit;
  logic                  w_revoke;

  assign w_elig = w_req_live & ~r_stale;

  // First eligible master scanning ptr, ptr+1, ... with wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < MASTERS; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= MASTERS) idx = idx - MASTERS;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_pick  = MS_W'(idx);
      end
    end
  end

  assign w_g_live = w_req_live[r_g];
  assign w_wd_hit = (TIMEOUT != 0) && (r_wd == WD_W'(TIMEOUT - 1));

  always_comb begin
    w_next   = r_state;
    w_revoke = 1'b0;
    case (r_state)
      ARB_IDLE:  if (w_found) w_next = ARB_GRANT;
      ARB_GRANT: begin
        // A release in the same cycle as the watchdog hit takes priority.
        if (!w_g_live) begin
          w_next = ARB_TURN;
        end else if (w_wd_hit) begin
          w_next   = ARB_TURN;
          w_revoke = 1'b1;
        end
      end
      ARB_TURN:  w_next = ARB_IDLE;
      default:   w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_g     <= '0;
      r_ptr   <= '0;
      r_sid   <= '0;
      r_wd    <= '0;
      r_stale <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_to    <= w_revoke;
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_g   <= w_pick;
            r_sid <= w_req_id[w_pick];
            r_wd  <= '0;
          end
        end
        ARB_GRANT: r_wd <= r_wd + WD_W'(1);
        ARB_TURN:  r_ptr <= (r_g == MS_W'(MASTERS - 1)) ? '0 : r_g + MS_W'(1);
        default: ;
      endcase
      // A timed-out master stays ineligible until its receiver sees the line drop.
      for (int i = 0; i < MASTERS; i++) begin
        if (w_rx_idle[i])                         r_stale[i] <= 1'b0;
        else if (w_revoke && (r_g == MS_W'(i)))   r_stale[i] <= 1'b1;
      end
    end
  end

  assign bus_busy   = (r_state == ARB_GRANT);
  assign arbCont    = bus_busy ? (MASTERS'(1) << r_g) : '0;
  assign slave_sel  = bus_busy ? (SLAVES'(1) << r_sid) : '0;
  assign master_sel = bus_busy ? r_g : '0;
  assign timeout    = r_to;
  assign bad_id     = |w_bad;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Randomized and directed bench for serial_bus_arbiter, checked against a
// transaction-level model of frames, grants, watchdog and turnaround.
module tb_serial_bus_arbiter;

  localparam int M = 2;
  localparam int S = 3;
  localparam int W = 2;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [M-1:0] arbSend;
  logic [M-1:0] arbCont;
  logic [S-1:0] slave_sel;
  logic [0:0]   master_sel;
  logic         bus_busy;
  logic         timeout;
  logic         bad_id;

  always #5 clk = ~clk;

  serial_bus_arbiter #(
    .MASTERS    (M),
    .SLAVES     (S),
    .SLAVE_ID_W (W),
    .TIMEOUT    (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arbSend    (arbSend),
    .arbCont    (arbCont),
    .slave_sel  (slave_sel),
    .master_sel (master_sel),
    .bus_busy   (bus_busy),
    .timeout    (timeout),
    .bad_id     (bad_id)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Model: ph = number of frame bits seen (0 idle, 1..W reading ID, W+1 holding).
  int ph [M];
  int idv [M];
  bit mbad [M];
  bit stale [M];
  bit busy, dead;
  int owner, sid, gcnt, ptr;
  int e_cont, e_ssel, e_msel, e_busy, e_to, e_bad;

  bit q [M][$];
  bit refill = 1'b0;

  task automatic model_step(input logic [M-1:0] s, input logic r);
    bit live [M];
    bit to_p, bad_p, found;
    int idx;
    if (r) begin
      for (int i = 0; i < M; i++) begin
        ph[i] = 0; idv[i] = 0; mbad[i] = 0; stale[i] = 0;
      end
      busy = 0; dead = 0; owner = 0; sid = 0; gcnt = 0; ptr = 0;
      e_cont = 0; e_ssel = 0; e_msel = 0; e_busy = 0; e_to = 0; e_bad = 0;
      return;
    end
    for (int i = 0; i < M; i++) live[i] = (ph[i] == W + 1) && !mbad[i] && s[i];
    to_p = 0;
    if (dead) begin
      dead = 0;
    end else if (busy) begin
      if (!live[owner]) begin
        busy = 0; dead = 1; ptr = (owner + 1) % M;
      end else if (gcnt == T - 1) begin
        busy = 0; dead = 1; ptr = (owner + 1) % M; to_p = 1;
      end else begin
        gcnt++;
      end
    end else begin
      found = 0;
      for (int k = 0; k < M; k++) begin
        idx = (ptr + k) % M;
        if (!found && live[idx] && !stale[idx]) begin
          found = 1; busy = 1; owner = idx; sid = idv[idx]; gcnt = 0;
        end
      end
    end
    for (int i = 0; i < M; i++) if (ph[i] == 0) stale[i] = 0;
    if (to_p) stale[owner] = 1;
    bad_p = 0;
    for (int i = 0; i < M; i++) begin
      if (ph[i] == 0) begin
        if (s[i]) begin ph[i] = 1; idv[i] = 0; end
      end else if (ph[i] <= W) begin
        idv[i] = idv[i] * 2 + int'(s[i]);
        if (ph[i] == W) begin
          mbad[i] = (idv[i] >= S);
          bad_p   = bad_p | mbad[i];
        end
        ph[i]++;
      end else if (!s[i]) begin
        ph[i] = 0; mbad[i] = 0;
      end
    end
    e_busy = busy;
    e_cont = busy ? (1 << owner) : 0;
    e_ssel = busy ? (1 << sid) : 0;
    e_msel = busy ? owner : 0;
    e_to   = to_p;
    e_bad  = bad_p;
  endtask

  task automatic compare_outputs();
    check("arbCont",    32'(arbCont),    e_cont);
    check("slave_sel",  32'(slave_sel),  e_ssel);
    check("master_sel", 32'(master_sel), e_msel);
    check("bus_busy",   32'(bus_busy),   e_busy);
    check("timeout",    32'(timeout),    e_to);
    check("bad_id",     32'(bad_id),     e_bad);
  endtask

  task automatic push_frame(input int m, input int idle, input int id, input int hold);
    repeat (idle) q[m].push_back(1'b0);
    q[m].push_back(1'b1);
    for (int b = W - 1; b >= 0; b--) q[m].push_back(((id >> b) & 1) != 0);
    repeat (hold) q[m].push_back(1'b1);
    q[m].push_back(1'b0);
  endtask

  task automatic run(input int n);
    logic [M-1:0] s;
    logic         r;
    repeat (n) begin
      @(negedge clk);
      compare_outputs();
      for (int i = 0; i < M; i++) begin
        if (q[i].size() == 0 && refill)
          push_frame(i, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 24));
        s[i] = (q[i].size() != 0) ? q[i].pop_front() : 1'b0;
      end
      r = refill && ($urandom_range(0, 399) == 0);
      arbSend = s;
      rst     = r;
      model_step(s, r);
    end
  endtask

  task automatic do_reset(input int n, input logic [M-1:0] s);
    repeat (n) begin
      @(negedge clk);
      compare_outputs();
      arbSend = s;
      rst     = 1'b1;
      model_step(s, 1'b1);
    end
  endtask

  initial begin
    rst     = 1'b1;
    arbSend = 2'b11;
    model_step(2'b11, 1'b1);
    do_reset(3, 2'b11);
    do_reset(1, 2'b00);

    push_frame(1, 0, 2, 10);            // single request, slave 2
    run(20);
    push_frame(0, 0, 2, 6);             // contention, master 0 wins first
    push_frame(1, 0, 1, 12);
    run(30);
    push_frame(0, 0, 0, 40);            // master 0 overruns the watchdog
    push_frame(1, 3, 1, 8);
    run(60);
    push_frame(0, 0, 1, 5);
    run(15);
    push_frame(0, 0, 3, 5);             // illegal slave ID
    run(12);
    push_frame(1, 0, 0, 20);            // reset while granted
    run(8);
    do_reset(1, 2'b11);
    for (int i = 0; i < M; i++) q[i].delete();
    run(6);

    refill = 1'b1;
    run(4000);
    refill = 1'b0;
    for (int i = 0; i < M; i++) q[i].delete();
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
